// File: rtl/seg_pkg.sv
// Shared seven-segment definitions for the segment encoder and seg_rx.
// Patterns are active-high, bit0=a ... bit6=g.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3f;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5b;
    localparam logic [6:0] SEG_3     = 7'h4f;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6d;
    localparam logic [6:0] SEG_6     = 7'h7d;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7f;
    localparam logic [6:0] SEG_9     = 7'h6f;
    localparam logic [6:0] SEG_H     = 7'h76;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_L     = 7'h38;
    localparam logic [6:0] SEG_U     = 7'h3e;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_BLANK = 4'hf;

    // Returns {err, code}; letters O and B alias to 0 and 8 on purpose.
    function automatic logic [4:0] seg_decode(input logic [6:0] pattern);
        logic [4:0] res;
        res = 5'b1_0000;
        case (pattern)
            SEG_0:     res = {1'b0, 4'd0};
            SEG_1:     res = {1'b0, 4'd1};
            SEG_2:     res = {1'b0, 4'd2};
            SEG_3:     res = {1'b0, 4'd3};
            SEG_4:     res = {1'b0, 4'd4};
            SEG_5:     res = {1'b0, 4'd5};
            SEG_6:     res = {1'b0, 4'd6};
            SEG_7:     res = {1'b0, 4'd7};
            SEG_8:     res = {1'b0, 4'd8};
            SEG_9:     res = {1'b0, 4'd9};
            SEG_H:     res = {1'b0, 4'd10};
            SEG_E:     res = {1'b0, 4'd11};
            SEG_L:     res = {1'b0, 4'd12};
            SEG_U:     res = {1'b0, 4'd13};
            SEG_A:     res = {1'b0, 4'd14};
            SEG_BLANK: res = {1'b0, CODE_BLANK};
            default:   res = 5'b1_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg_fifo.sv
// Synchronous first-word-fall-through FIFO; dout is the head entry whenever !empty.
module seg_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/seg_rx.sv
// Seven-segment bus receiver: synchronise, wait for a stable pattern, decode it
// and queue symbol changes into a FWFT FIFO with a sticky overflow flag.
module seg_rx
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int SKIP_BLANK    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [6:0]                    HEX_IN,
    output logic [3:0]                    code_o,
    output logic                          err_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o
);

    localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] RUN_ACC = 8'(STABLE_CYCLES - 1);

    logic [6:0] s1;
    logic [6:0] s2;
    logic [6:0] pat;
    logic [6:0] last_pat;
    logic       have_last;
    logic [7:0] run_cnt;
    logic       accept;
    logic       changed;
    logic       push;
    logic       pop;
    logic [4:0] dec;
    logic [4:0] head;
    logic       empty;
    logic       full;

    assign pat     = ~s2;
    assign accept  = (s1 == s2) && (run_cnt == RUN_ACC);
    assign dec     = seg_decode(pat);
    assign changed = !have_last || (pat != last_pat);
    // A blank still becomes last_pat so a repeated symbol around it is queued again.
    assign push    = accept && changed && !((SKIP_BLANK != 0) && (pat == SEG_BLANK));
    assign pop     = valid_o && ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 7'h7f;
            s2         <= 7'h7f;
            run_cnt    <= '0;
            have_last  <= 1'b0;
            last_pat   <= '0;
            overflow_o <= 1'b0;
        end else begin
            s1 <= HEX_IN;
            s2 <= s1;
            if (s1 != s2)
                run_cnt <= '0;
            else if (run_cnt != RUN_MAX)
                run_cnt <= run_cnt + 1'b1;
            if (accept && changed) begin
                last_pat  <= pat;
                have_last <= 1'b1;
            end
            if (push && full && !pop)
                overflow_o <= 1'b1;
        end
    end

    seg_fifo #(
        .WIDTH (5),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (dec),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .level (level_o)
    );

    assign valid_o = !empty;
    assign code_o  = valid_o ? head[3:0] : 4'd0;
    assign err_o   = valid_o ? head[4]   : 1'b0;

endmodule

// File: tb/tb_seg_rx.sv
// Directed bench for seg_rx with a run-length/queue reference model checked every cycle.
module tb_seg_rx;

    localparam int S     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] hex_in;
    logic       ready_i;
    logic [3:0] code_o;
    logic       err_o;
    logic       valid_o;
    logic [2:0] level_o;
    logic       overflow_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg_rx #(
        .STABLE_CYCLES (S),
        .FIFO_DEPTH    (DEPTH),
        .SKIP_BLANK    (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .HEX_IN     (hex_in),
        .code_o     (code_o),
        .err_o      (err_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .level_o    (level_o),
        .overflow_o (overflow_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode table, {err, code}.
    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        case (p)
            7'h3f: return 5'd0;   7'h06: return 5'd1;   7'h5b: return 5'd2;
            7'h4f: return 5'd3;   7'h66: return 5'd4;   7'h6d: return 5'd5;
            7'h7d: return 5'd6;   7'h07: return 5'd7;   7'h7f: return 5'd8;
            7'h6f: return 5'd9;   7'h76: return 5'd10;  7'h79: return 5'd11;
            7'h38: return 5'd12;  7'h3e: return 5'd13;  7'h77: return 5'd14;
            7'h00: return 5'd15;
            default: return 5'b1_0000;
        endcase
    endfunction

    // Model: a sampled bus value is accepted once it has been seen on S+1
    // consecutive edges; the push lands one edge later.
    logic [4:0] mq[$];
    bit         m_ovf;
    bit         m_have;
    logic [6:0] m_last;
    logic [6:0] m_cur;
    int         m_run;
    bit         m_pend;
    bit         started = 0;

    always @(posedge clk) begin
        bit         do_pop;
        bit         do_push;
        logic [6:0] p;
        if (rst) begin
            mq.delete();
            m_ovf   = 0;
            m_have  = 0;
            m_last  = '0;
            m_cur   = 7'h7f;
            m_run   = 2;
            m_pend  = 0;
            started = 1;
        end else if (started) begin
            do_pop  = (mq.size() > 0) && ready_i;
            do_push = 0;
            p       = ~m_cur;
            if (m_pend && (!m_have || p != m_last)) begin
                m_last  = p;
                m_have  = 1;
                do_push = (p != 7'h00);
            end
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                if (mq.size() < DEPTH) mq.push_back(ref_decode(p));
                else m_ovf = 1;
            end
            if (hex_in == m_cur) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_cur = hex_in;
                m_run = 1;
            end
            m_pend = (m_run == S + 1);
        end
    end

    // Per-cycle compare plus capture of DUT pops for message checks.
    logic [3:0] lat_code;
    bit         lat_valid;
    int         popped[$];

    always @(negedge clk) begin
        if (started && !rst) begin
            chk("valid", valid_o, mq.size() > 0);
            chk("level", level_o, mq.size());
            chk("overflow", overflow_o, m_ovf);
            chk("code", code_o, (mq.size() > 0) ? int'(mq[0][3:0]) : 0);
            chk("err", err_o, (mq.size() > 0) ? int'(mq[0][4]) : 0);
        end
        lat_valid = valid_o;
        lat_code  = code_o;
    end

    always @(posedge clk) begin
        if (!rst && started && lat_valid && ready_i) popped.push_back(int'(lat_code));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic show(input logic [6:0] seg_pat, input int n);
        hex_in = ~seg_pat;
        cyc(n);
    endtask

    task automatic chk_popped(input string name, input int exp[$]);
        chk({name, "_count"}, popped.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk(name, (i < popped.size()) ? popped[i] : -1, exp[i]);
    endtask

    initial begin
        rst     = 1'b1;
        hex_in  = 7'h7f;
        ready_i = 1'b0;
        cyc(2);
        chk("rst_valid", valid_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_code", code_o, 0);

        // 1: digit 2, latency to edge 5, then pop
        rst    = 1'b0;
        hex_in = ~7'h5b;
        cyc(5);
        chk("t1_early_valid", valid_o, 0);
        cyc(1);
        chk("t1_valid", valid_o, 1);
        chk("t1_code", code_o, 2);
        chk("t1_err", err_o, 0);
        chk("t1_level", level_o, 1);
        ready_i = 1'b1;
        cyc(1);
        chk("t1_pop_valid", valid_o, 0);
        chk("t1_pop_level", level_o, 0);
        cyc(4);

        // 2: glitch rejection, then a real digit 1
        ready_i = 1'b0;
        show(7'h06, 3);
        show(7'h00, 10);
        chk("t2_glitch_valid", valid_o, 0);
        show(7'h06, 6);
        chk("t2_valid", valid_o, 1);
        chk("t2_code", code_o, 1);
        ready_i = 1'b1;
        cyc(3);

        // 3: HELLO-style messages with consumer always ready
        popped.delete();
        show(7'h76, 8); show(7'h79, 8); show(7'h38, 8);
        show(7'h00, 8); show(7'h38, 8); show(7'h3f, 10);
        chk_popped("t3_blank_msg", '{10, 11, 12, 12, 0});
        popped.delete();
        show(7'h76, 8); show(7'h79, 8); show(7'h38, 8);
        show(7'h38, 8); show(7'h3f, 10);
        chk_popped("t3_plain_msg", '{10, 11, 12, 0});

        // 4: illegal pattern, queued once
        ready_i = 1'b0;
        show(7'h01, 6);
        chk("t4_valid", valid_o, 1);
        chk("t4_err", err_o, 1);
        chk("t4_code", code_o, 0);
        cyc(10);
        chk("t4_level", level_o, 1);
        ready_i = 1'b1;
        cyc(1);
        ready_i = 1'b0;

        // 5: overflow with five digits into four entries
        show(7'h06, 8); show(7'h5b, 8); show(7'h4f, 8);
        show(7'h66, 8); show(7'h6d, 8);
        chk("t5_level", level_o, 4);
        chk("t5_ovf", overflow_o, 1);
        popped.delete();
        ready_i = 1'b1;
        cyc(6);
        chk_popped("t5_drain", '{1, 2, 3, 4});
        chk("t5_ovf_sticky", overflow_o, 1);
        ready_i = 1'b0;

        // 6: reset with entries queued and an accept in flight
        show(7'h07, 8); show(7'h6f, 8);
        show(7'h7d, 4);
        chk("t6_pre_level", level_o, 2);
        rst    = 1'b1;
        hex_in = ~7'h6f;
        cyc(1);
        rst = 1'b0;
        chk("t6_rst_valid", valid_o, 0);
        chk("t6_rst_level", level_o, 0);
        chk("t6_rst_ovf", overflow_o, 0);
        cyc(8);
        chk("t6_requeue_valid", valid_o, 1);
        chk("t6_requeue_code", code_o, 9);
        chk("t6_requeue_level", level_o, 1);
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
